// File: rtl/instr_fetch_decode.sv
// PDP-8 fetch/decode stage: fetches a word at PC, resolves one level of indirection, issues decoded opcodes to EXEC.
// Latency: new_instr 3 cycles after the fetch request (direct) or 5 cycles (indirect).
// Backpressure: opcodes are held from issue until EXEC retires via the falling edge of stall; HLT parks the stage until reset.

package pdp8_pkg;
  localparam int ADDR_WIDTH = 12;
  localparam int DATA_WIDTH = 12;

  typedef struct packed {
    logic                  AND;
    logic                  TAD;
    logic                  ISZ;
    logic                  DCA;
    logic                  JMS;
    logic                  JMP;
    logic [ADDR_WIDTH-1:0] mem_inst_addr;
  } pdp_mem_opcode_s;

  typedef struct packed {
    logic NOP;
    logic IAC;
    logic RAL;
    logic RTL;
    logic RAR;
    logic RTR;
    logic CML;
    logic CMA;
    logic CIA;
    logic CLL;
    logic CLA;
    logic CLA_CLL;
    logic HLT;
    logic SKP;
    logic SNL;
    logic SZL;
    logic SZA;
    logic SNA;
    logic SMA;
    logic SPA;
  } pdp_op7_opcode_s;
endpackage

module instr_fetch_decode
  import pdp8_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = 12'o200
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  ifu_rd_req,
  output logic [ADDR_WIDTH-1:0] ifu_rd_addr,
  input  logic [DATA_WIDTH-1:0] ifu_rd_data,
  output pdp_mem_opcode_s       pdp_mem_opcode,
  output pdp_op7_opcode_s       pdp_op7_opcode,
  output logic                  new_instr,
  output logic [ADDR_WIDTH-1:0] PC_value,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_PC
);

  typedef enum logic [3:0] {
    IDLE, FETCH, FETCH_WAIT, DECODE, IND_REQ, IND_WAIT,
    ISSUE, WAIT_STALL, WAIT_RETIRE, HALT
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] ir_q, ir_d;
  logic [ADDR_WIDTH-1:0] ea_q, ea_d;
  pdp_mem_opcode_s       mem_op_q, mem_op_d;
  pdp_op7_opcode_s       op7_q, op7_d;

  logic [2:0]            opcode;
  logic                  i_bit;
  logic                  z_bit;
  logic [ADDR_WIDTH-1:0] ea_direct;
  logic [ADDR_WIDTH-1:0] issue_ea;
  logic                  load_issue;

  // Memory-reference opcodes 0..5 map onto one flag each; IOT and operate words carry no memory flag.
  function automatic pdp_mem_opcode_s decode_mem(input logic [2:0] op, input logic [ADDR_WIDTH-1:0] ea);
    pdp_mem_opcode_s r;
    r = '0;
    case (op)
      3'd0: r.AND = 1'b1;
      3'd1: r.TAD = 1'b1;
      3'd2: r.ISZ = 1'b1;
      3'd3: r.DCA = 1'b1;
      3'd4: r.JMS = 1'b1;
      3'd5: r.JMP = 1'b1;
      default: r = '0;
    endcase
    if (op <= 3'd5) r.mem_inst_addr = ea;
    return r;
  endfunction

  // Operate words are matched exactly; any combination not in the list decodes to no flag.
  function automatic pdp_op7_opcode_s decode_op7(input logic [DATA_WIDTH-1:0] w);
    pdp_op7_opcode_s r;
    r = '0;
    case (w)
      12'o7000: r.NOP     = 1'b1;
      12'o7001: r.IAC     = 1'b1;
      12'o7004: r.RAL     = 1'b1;
      12'o7006: r.RTL     = 1'b1;
      12'o7010: r.RAR     = 1'b1;
      12'o7012: r.RTR     = 1'b1;
      12'o7020: r.CML     = 1'b1;
      12'o7040: r.CMA     = 1'b1;
      12'o7041: r.CIA     = 1'b1;
      12'o7100: r.CLL     = 1'b1;
      12'o7200: r.CLA     = 1'b1;
      12'o7300: r.CLA_CLL = 1'b1;
      12'o7402: r.HLT     = 1'b1;
      12'o7410: r.SKP     = 1'b1;
      12'o7420: r.SNL     = 1'b1;
      12'o7430: r.SZL     = 1'b1;
      12'o7440: r.SZA     = 1'b1;
      12'o7450: r.SNA     = 1'b1;
      12'o7500: r.SMA     = 1'b1;
      12'o7510: r.SPA     = 1'b1;
      default:  r         = '0;
    endcase
    return r;
  endfunction

  // Instruction field split and direct effective address (page 0 or current page).
  always_comb begin
    opcode    = ir_q[11:9];
    i_bit     = ir_q[8];
    z_bit     = ir_q[7];
    ea_direct = z_bit ? {pc_q[11:7], ir_q[6:0]} : {5'b0, ir_q[6:0]};
  end

  // Next-state, memory request and issue logic.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    ea_d        = ea_q;
    mem_op_d    = mem_op_q;
    op7_d       = op7_q;
    ifu_rd_req  = 1'b0;
    ifu_rd_addr = '0;
    new_instr   = 1'b0;
    issue_ea    = ea_q;
    load_issue  = 1'b0;

    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        ifu_rd_req  = 1'b1;
        ifu_rd_addr = pc_q;
        state_d     = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        ir_d    = ifu_rd_data;
        state_d = DECODE;
      end
      DECODE: begin
        ea_d = ea_direct;
        if ((opcode <= 3'd5) && i_bit) begin
          state_d = IND_REQ;
        end else begin
          issue_ea   = ea_direct;
          load_issue = 1'b1;
          state_d    = ISSUE;
        end
      end
      IND_REQ: begin
        ifu_rd_req  = 1'b1;
        ifu_rd_addr = ea_q;
        state_d     = IND_WAIT;
      end
      IND_WAIT: begin
        // Plain indirection everywhere, including the 0o010-0o017 window.
        ea_d       = ifu_rd_data;
        issue_ea   = ifu_rd_data;
        load_issue = 1'b1;
        state_d    = ISSUE;
      end
      ISSUE: begin
        new_instr = 1'b1;
        state_d   = WAIT_STALL;
      end
      WAIT_STALL: begin
        if (stall) state_d = WAIT_RETIRE;
      end
      WAIT_RETIRE: begin
        if (!stall) begin
          pc_d    = branch_taken ? branch_PC : pc_q + 12'd1;
          state_d = op7_q.HLT ? HALT : FETCH;
        end
      end
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase

    // Opcodes become visible in the ISSUE cycle itself, so they load on the way in.
    if (load_issue) begin
      mem_op_d = decode_mem(opcode, issue_ea);
      op7_d    = (opcode == 3'd7) ? decode_op7(ir_q) : '0;
    end

    // Outputs stay held through the retire cycle and clear as the next fetch starts.
    if (state_d == FETCH) begin
      mem_op_d = '0;
      op7_d    = '0;
    end
  end

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      pc_q     <= START_ADDR;
      ir_q     <= '0;
      ea_q     <= '0;
      mem_op_q <= '0;
      op7_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      ea_q     <= ea_d;
      mem_op_q <= mem_op_d;
      op7_q    <= op7_d;
    end
  end

  assign base_addr      = START_ADDR;
  assign PC_value       = pc_q;
  assign pdp_mem_opcode = mem_op_q;
  assign pdp_op7_opcode = op7_q;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Bench for instr_fetch_decode: memory responder, EXEC-side driver, and a transaction-level model.
// The model predicts every read request, issue cycle, decoded opcode and PC from the instruction words.
// Directed program first, then a randomized program with a wrap, a mid-retire reset and a final HLT.
`timescale 1ns/1ps
module tb_instr_fetch_decode;
  import pdp8_pkg::*;

  localparam logic [11:0] START = 12'o200;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [11:0]     base_addr;
  logic            ifu_rd_req;
  logic [11:0]     ifu_rd_addr;
  logic [11:0]     ifu_rd_data;
  pdp_mem_opcode_s pdp_mem_opcode;
  pdp_op7_opcode_s pdp_op7_opcode;
  logic            new_instr;
  logic [11:0]     PC_value;
  logic            stall;
  logic            branch_taken;
  logic [11:0]     branch_PC;

  int n_checks = 0;
  int n_fail   = 0;

  logic [11:0] mem [0:4095];
  logic [11:0] op7_tab [0:19] = '{12'o7000, 12'o7001, 12'o7004, 12'o7006, 12'o7010,
                                  12'o7012, 12'o7020, 12'o7040, 12'o7041, 12'o7100,
                                  12'o7200, 12'o7300, 12'o7402, 12'o7410, 12'o7420,
                                  12'o7430, 12'o7440, 12'o7450, 12'o7500, 12'o7510};

  instr_fetch_decode #(.START_ADDR(START)) dut (
    .clk(clk), .reset_n(reset_n), .base_addr(base_addr),
    .ifu_rd_req(ifu_rd_req), .ifu_rd_addr(ifu_rd_addr), .ifu_rd_data(ifu_rd_data),
    .pdp_mem_opcode(pdp_mem_opcode), .pdp_op7_opcode(pdp_op7_opcode),
    .new_instr(new_instr), .PC_value(PC_value),
    .stall(stall), .branch_taken(branch_taken), .branch_PC(branch_PC)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0o expected %0o", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: no response within cycle budget", name);
  endtask

  // Model: one-hot position of an operate word in the instruction list (first list entry is the top struct bit).
  function automatic logic [19:0] exp_op7(input logic [11:0] w);
    logic [19:0] r = '0;
    for (int i = 0; i < 20; i++) if (w == op7_tab[i]) r[19-i] = 1'b1;
    return r;
  endfunction

  // Model: memory-reference flags (AND on top, JMP lowest) plus the effective address.
  function automatic logic [17:0] exp_mem(input logic [2:0] op, input logic [11:0] ea);
    logic [17:0] r = '0;
    if (op <= 3'd5) begin
      r[17-int'(op)] = 1'b1;
      r[11:0]        = ea;
    end
    return r;
  endfunction

  function automatic logic [11:0] gen_word();
    logic [11:0] w;
    int k = $urandom_range(0, 9);
    if (k < 6)       w = {k[2:0], 9'($urandom)};
    else if (k == 6) w = {3'd6, 9'($urandom)};
    else if (k < 9)  w = op7_tab[$urandom_range(0, 19)];
    else             w = {3'd7, 9'($urandom)};
    if (w == 12'o7402) w = 12'o7000;
    return w;
  endfunction

  // Memory: data for a request appears during the following cycle, random junk otherwise.
  logic        pend;
  logic [11:0] pend_addr;
  initial begin
    pend = 1'b0;
    pend_addr = '0;
    ifu_rd_data = '0;
    forever begin
      @(negedge clk);
      ifu_rd_data = pend ? mem[pend_addr] : 12'($urandom);
      pend = ifu_rd_req;
      pend_addr = ifu_rd_addr;
    end
  end

  // Compare process: predicts request/issue cycles and held outputs from the instruction stream.
  int          cyc = 0;
  int          exp_fetch = -1, exp_ind = -1, exp_new = -1;
  logic [11:0] m_pc = START;
  logic [11:0] exp_ind_addr = '0;
  logic [17:0] exp_m = '0;
  logic [19:0] exp_o = '0;
  bit          holding = 0, halted = 0, in_reset = 1, seen_stall = 0;
  initial begin
    logic [11:0] w, ea;
    logic [2:0]  op;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        m_pc = START; exp_fetch = -1; exp_ind = -1; exp_new = -1;
        holding = 0; halted = 0; in_reset = 1;
        continue;
      end
      if (in_reset) begin
        in_reset = 0;
        exp_fetch = cyc + 1;
      end
      check("base_addr", 32'(base_addr), 32'(START));
      check("PC_value", 32'(PC_value), 32'(m_pc));
      check("rd_req", 32'(ifu_rd_req), 32'((cyc == exp_fetch) || (cyc == exp_ind)));
      if (cyc == exp_fetch) begin
        check("fetch_addr", 32'(ifu_rd_addr), 32'(m_pc));
        w  = mem[m_pc];
        op = w[11:9];
        ea = w[7] ? {m_pc[11:7], w[6:0]} : {5'b0, w[6:0]};
        if (op <= 3'd5 && w[8]) begin
          exp_ind = cyc + 3;
          exp_ind_addr = ea;
          ea = mem[ea];
          exp_new = cyc + 5;
        end else begin
          exp_new = cyc + 3;
        end
        exp_m = exp_mem(op, ea);
        exp_o = (op == 3'd7) ? exp_op7(w) : '0;
        holding = 0;
      end
      if (cyc == exp_ind) check("ind_addr", 32'(ifu_rd_addr), 32'(exp_ind_addr));
      check("new_instr", 32'(new_instr), 32'(cyc == exp_new));
      if (cyc == exp_new) begin
        holding = 1;
        seen_stall = 0;
      end
      if (holding) begin
        check("mem_opcode", 32'(pdp_mem_opcode), 32'(exp_m));
        check("op7_opcode", 32'(pdp_op7_opcode), 32'(exp_o));
      end else begin
        check("mem_opcode_clear", 32'(pdp_mem_opcode), 32'(0));
        check("op7_opcode_clear", 32'(pdp_op7_opcode), 32'(0));
      end
      if (holding && !halted && cyc > exp_new) begin
        if (stall) seen_stall = 1;
        else if (seen_stall) begin
          m_pc = branch_taken ? branch_PC : m_pc + 12'd1;
          if (exp_o == exp_op7(12'o7402)) halted = 1;
          else exp_fetch = cyc + 1;
        end
      end
    end
  end

  // EXEC side: wait for issue, stall for hold cycles, then retire with the given branch result.
  task automatic run_instr(input bit taken, input logic [11:0] bpc, input int hold, input bit early,
                           input bit plant_hlt, output pdp_mem_opcode_s gm, output pdp_op7_opcode_s go);
    int n = 0;
    gm = '0;
    go = '0;
    @(posedge clk);
    #1;
    stall = early;
    branch_taken = 1'($urandom);
    branch_PC = 12'($urandom);
    while (new_instr !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30) begin
      fail_timeout("new_instr_wait");
      stall = 1'b0;
      return;
    end
    gm = pdp_mem_opcode;
    go = pdp_op7_opcode;
    if (plant_hlt) mem[bpc] = 12'o7402;
    stall = 1'b1;
    repeat (hold + 1) @(posedge clk);
    #1;
    stall = 1'b0;
    branch_taken = taken;
    branch_PC = bpc;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_PC"}, 32'(PC_value), 32'(12'o200));
    check({tag, "_rd_req"}, 32'(ifu_rd_req), 32'(0));
    check({tag, "_rd_addr"}, 32'(ifu_rd_addr), 32'(0));
    check({tag, "_new_instr"}, 32'(new_instr), 32'(0));
    check({tag, "_mem_op"}, 32'(pdp_mem_opcode), 32'(0));
    check({tag, "_op7"}, 32'(pdp_op7_opcode), 32'(0));
  endtask

  initial begin
    pdp_mem_opcode_s gm;
    pdp_op7_opcode_s go;
    logic [11:0]     bpc;
    bit              taken;
    int              reqs, n;

    reset_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_PC = '0;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    mem[12'o200] = 12'o1377;
    mem[12'o201] = 12'o5420;
    mem[12'o020] = 12'o0400;
    mem[12'o400] = 12'o7300;
    mem[12'o401] = 12'o6001;
    mem[12'o402] = 12'o7402;

    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst0");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_fetch", 32'({ifu_rd_req, ifu_rd_addr}), 32'({1'b1, 12'o200}));

    run_instr(1'b0, 12'o0, 1, 1'b0, 1'b0, gm, go);
    check("tad_flag", 32'(gm.TAD), 32'(1));
    check("tad_ea", 32'(gm.mem_inst_addr), 32'(12'o377));
    @(posedge clk);
    #1;
    check("tad_retire_pc", 32'(PC_value), 32'(12'o201));

    run_instr(1'b1, 12'o400, 2, 1'b1, 1'b0, gm, go);
    check("jmp_flag", 32'(gm.JMP), 32'(1));
    check("jmp_ea", 32'(gm.mem_inst_addr), 32'(12'o400));
    @(posedge clk);
    #1;
    check("jmp_next_fetch", 32'({ifu_rd_req, ifu_rd_addr}), 32'({1'b1, 12'o400}));

    run_instr(1'b0, 12'o0, 1, 1'b1, 1'b0, gm, go);
    check("cla_cll_flag", 32'(go.CLA_CLL), 32'(1));
    check("cla_cll_onehot", 32'($countones(go)), 32'(1));
    run_instr(1'b0, 12'o0, 3, 1'b0, 1'b0, gm, go);
    check("iot_noflags", 32'({gm, go}), 32'(0));
    run_instr(1'b0, 12'o0, 1, 1'b0, 1'b0, gm, go);
    check("hlt_flag", 32'(go.HLT), 32'(1));
    reqs = 0;
    repeat (40) begin
      @(negedge clk);
      if (ifu_rd_req) reqs++;
    end
    check("halt_no_req", 32'(reqs), 32'(0));
    check("halt_held", 32'(pdp_op7_opcode.HLT), 32'(1));

    // Randomized program, entered by resetting out of HALT.
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = gen_word();
    #1;
    check_reset_vals("rst1");
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    for (int k = 0; k <= 150; k++) begin
      taken = ($urandom_range(0, 2) == 0);
      bpc   = 12'($urandom);
      if (k == 20) begin taken = 1'b1; bpc = 12'o7777; end
      if (k == 21) taken = 1'b0;
      if (k == 149) begin taken = 1'b1; bpc = 12'o3456; end
      if (k == 80) begin
        // Assert reset while the stage sits in the retire wait with EXEC stalled.
        @(posedge clk);
        #1;
        stall = 1'b1;
        n = 0;
        while (new_instr !== 1'b1 && n < 30) begin
          @(negedge clk);
          n++;
        end
        if (n >= 30) fail_timeout("new_instr_wait_rst");
        repeat (3) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check_reset_vals("rst_mid");
        stall = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("restart_fetch", 32'({ifu_rd_req, ifu_rd_addr}), 32'({1'b1, 12'o200}));
        continue;
      end
      run_instr(taken, bpc, $urandom_range(1, 4), 1'($urandom), k == 149, gm, go);
      if (k == 21) begin
        @(posedge clk);
        #1;
        check("wrap_fetch", 32'({ifu_rd_req, ifu_rd_addr}), 32'({1'b1, 12'o0000}));
      end
    end
    check("final_hlt", 32'(go.HLT), 32'(1));
    reqs = 0;
    repeat (30) begin
      @(negedge clk);
      if (ifu_rd_req) reqs++;
    end
    check("final_halt_no_req", 32'(reqs), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
